// File: rtl/imm_encoder.sv
// imm_encoder: packs opcode, register fields, funct fields and a 32-bit
// immediate into an RV32I instruction word and streams it to instruction
// memory through a write port with an auto-incrementing word address.
//
// Optional feature macro: IMM_RANGE_CHECK_EN
//   defined   -> wr_err also flags immediates not representable in the format
//   undefined -> wr_err flags only unknown opcodes; immediates are truncated
//
// Handshakes (both sides): a transfer happens on a rising edge where
// valid && ready are both high. The upstream side may accept a new request
// in the same cycle the held word completes (in_ready = !wr_en || wr_ready),
// giving full throughput. While wr_en=1 && wr_ready=0, wr_data/wr_err and
// wr_addr hold stable (except that addr_clr re-addresses the held word).
module imm_encoder #(
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
    parameter int unsigned          ERRCNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          opcode,
    input  logic [4:0]          rd,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic [31:0]         imm,
    input  logic                addr_clr,
    output logic                wr_en,
    input  logic                wr_ready,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [31:0]         wr_data,
    output logic                wr_err,
    output logic [ERRCNT_W-1:0] err_count
);

    // Instruction format classes derived from the opcode.
    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_B   = 3'd2,
        FMT_U   = 3'd3,
        FMT_J   = 3'd4,
        FMT_R   = 3'd5,
        FMT_BAD = 3'd6
    } fmt_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    fmt_t                fmt;
    logic [31:0]         enc_word;
    logic                enc_err;
    logic                imm_bad;

    logic                wr_en_q;
    logic [31:0]         wr_data_q;
    logic                wr_err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ERRCNT_W-1:0] err_cnt_q;

    logic                accept;
    logic                complete;

    assign in_ready = !wr_en_q || wr_ready;
    assign accept   = in_valid && in_ready;
    assign complete = wr_en_q && wr_ready;

    // Classify the opcode into its encoding format.
    always_comb begin
        fmt = FMT_BAD;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111: fmt = FMT_I;
            7'b0100011:                         fmt = FMT_S;
            7'b1100011:                         fmt = FMT_B;
            7'b0110111, 7'b0010111:             fmt = FMT_U;
            7'b1101111:                         fmt = FMT_J;
            7'b0110011:                         fmt = FMT_R;
            default:                            fmt = FMT_BAD;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Flag immediates whose significant bits do not fit the format's field.
    always_comb begin
        imm_bad = 1'b0;
        case (fmt)
            FMT_I, FMT_S: imm_bad = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_B:        imm_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            FMT_J:        imm_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            FMT_U:        imm_bad = |imm[11:0];
            default:      imm_bad = 1'b0;
        endcase
    end
`else
    // Range checking is compiled out; immediates are silently truncated.
    always_comb begin
        imm_bad = 1'b0;
    end
`endif

    // Scatter the immediate and register fields into the instruction word.
    always_comb begin
        enc_word = NOP_WORD;
        enc_err  = imm_bad;
        case (fmt)
            FMT_I: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                               imm[4:1], imm[11], opcode};
            FMT_U: enc_word = {imm[31:12], rd, opcode};
            FMT_J: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12],
                               rd, opcode};
            FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            default: begin
                enc_word = NOP_WORD;
                enc_err  = 1'b1;
            end
        endcase
    end

    // Output stage: load on accept, drop wr_en once the held word completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_err_q  <= 1'b0;
        end else if (accept) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= enc_word;
            wr_err_q  <= enc_err;
        end else if (complete) begin
            wr_en_q   <= 1'b0;
        end
    end

    // Address counter: clear wins over advance; a completing write has
    // already used the current address in this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= BASE_ADDR;
        end else if (addr_clr) begin
            addr_q <= BASE_ADDR;
        end else if (complete) begin
            addr_q <= addr_q + ADDR_W'(4);
        end
    end

    // Saturating count of errored words that actually reached memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (complete && wr_err_q && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_data   = wr_data_q;
    assign wr_err    = wr_err_q;
    assign wr_addr   = addr_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized and directed stimulus for imm_encoder, checked
// every cycle against a behavioural model (arithmetic field packing, a
// one-word expected queue, model address and error counters).
module tb_imm_encoder;

    localparam int unsigned       ADDR_W    = 32;
    localparam logic [ADDR_W-1:0] BASE_ADDR = '0;
    localparam int unsigned       ERRCNT_W  = 8;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [31:0]         imm;
    logic                addr_clr;
    logic                wr_en;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [31:0]         wr_data;
    logic                wr_err;
    logic [ERRCNT_W-1:0] err_count;

    imm_encoder #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .ERRCNT_W (ERRCNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7   (funct7),
        .imm      (imm),
        .addr_clr (addr_clr),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .err_count(err_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit model_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {err, word} computed with shifts and masks straight from the
    // field layouts, plus signed range tests when the check is enabled.
    function automatic logic [32:0] model_enc(input logic [31:0] op, input logic [31:0] d,
                                              input logic [31:0] s1, input logic [31:0] s2,
                                              input logic [31:0] f3, input logic [31:0] f7,
                                              input logic [31:0] im);
        logic [31:0] w;
        bit          e;
        int          sv;
        sv = $signed(im);
        e  = 1'b0;
        case (op)
            32'h03, 32'h13, 32'h67: begin
                w = ((im & 32'hfff) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
`ifdef IMM_RANGE_CHECK_EN
                e = (sv < -2048) || (sv > 2047);
`endif
            end
            32'h23: begin
                w = (((im >> 5) & 32'h7f) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
                  | ((im & 32'h1f) << 7) | op;
`ifdef IMM_RANGE_CHECK_EN
                e = (sv < -2048) || (sv > 2047);
`endif
            end
            32'h63: begin
                w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3f) << 25) | (s2 << 20)
                  | (s1 << 15) | (f3 << 12) | (((im >> 1) & 32'hf) << 8)
                  | (((im >> 11) & 1) << 7) | op;
`ifdef IMM_RANGE_CHECK_EN
                e = (sv < -4096) || (sv > 4095) || (sv % 2 != 0);
`endif
            end
            32'h37, 32'h17: begin
                w = (im & 32'hffff_f000) | (d << 7) | op;
`ifdef IMM_RANGE_CHECK_EN
                e = (im % 4096) != 0;
`endif
            end
            32'h6f: begin
                w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3ff) << 21)
                  | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hff) << 12) | (d << 7) | op;
`ifdef IMM_RANGE_CHECK_EN
                e = (sv < -1048576) || (sv > 1048575) || (sv % 2 != 0);
`endif
            end
            32'h33: w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
            default: begin
                w = 32'h0000_0013;
                e = 1'b1;
            end
        endcase
        sv = 0;
        return {e, w};
    endfunction

    // ---------------- scoreboard ----------------
    logic [32:0]         exp_q[$];
    logic [ADDR_W-1:0]   m_addr;
    int unsigned         m_errcnt;

    // Compare on the falling edge (inputs and outputs are stable), then
    // advance the model by what the coming rising edge will do.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_addr   = BASE_ADDR;
            m_errcnt = 0;
        end else if (model_on) begin
            bit has_word;
            bit done;
            bit take;
            has_word = (exp_q.size() != 0);
            chk("wr_en", wr_en, has_word);
            chk("in_ready", in_ready, !has_word || wr_ready);
            chk("wr_addr", wr_addr, m_addr);
            chk("err_count", err_count, m_errcnt);
            if (has_word) begin
                chk("wr_data", wr_data, exp_q[0][31:0]);
                chk("wr_err", wr_err, exp_q[0][32]);
            end
            done = has_word && wr_ready;
            take = in_valid && (!has_word || wr_ready);
            if (done) begin
                logic [32:0] w;
                w = exp_q.pop_front();
                if (w[32] && m_errcnt < (1 << ERRCNT_W) - 1) m_errcnt++;
            end
            if (addr_clr) m_addr = BASE_ADDR;
            else if (done) m_addr = m_addr + 4;
            if (take) exp_q.push_back(model_enc(opcode, rd, rs1, rs2, funct3, funct7, imm));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] im);
        opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
        in_valid = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] im);
        int n;
        set_req(op, d, s1, s2, f3, f7, im);
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 50) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ops [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h7f};

    initial begin
        logic [32:0] exp_a;
        logic [32:0] exp_b;
        rst_n = 1'b0; in_valid = 1'b0; addr_clr = 1'b0; wr_ready = 1'b1;
        opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_wr_addr", wr_addr, BASE_ADDR);
        rst_n = 1'b1;
        model_on = 1'b1;
        tick();

        // Hand-computed words pin the model.
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        chk("addi_data", wr_data, 32'h0050_0093);
        chk("addi_addr", wr_addr, 0);
        chk("addi_err", wr_err, 0);
        chk("model_addi", model_enc(32'h13, 1, 0, 0, 0, 0, 5), {1'b0, 32'h0050_0093});
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hffff_fff8);
        chk("beq_data", wr_data, 32'hfe20_8ce3);
        chk("beq_addr", wr_addr, 4);
        send(7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        chk("jal_data", wr_data, 32'h0010_00ef);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        chk("addi_big_data", wr_data, 32'h8000_0093);
`ifdef IMM_RANGE_CHECK_EN
        chk("addi_big_err", wr_err, 1);
`else
        chk("addi_big_err", wr_err, 0);
`endif
        send(7'h7f, 5'd3, 5'd4, 5'd5, 3'd1, 7'd0, 32'h1234);
        chk("badop_data", wr_data, 32'h0000_0013);
        chk("badop_err", wr_err, 1);
        tick();
`ifdef IMM_RANGE_CHECK_EN
        chk("errcnt_two", err_count, 2);
`else
        chk("errcnt_one", err_count, 1);
`endif

        // Back-to-back requests into a stalled write port.
        wr_ready = 1'b0;
        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        exp_a = model_enc(32'h33, 7, 8, 9, 3'd5, 7'h20, 0);
        exp_b = model_enc(32'h23, 0, 2, 3, 3'd2, 0, 32'hffff_fffc);
        set_req(7'h33, 5'd7, 5'd8, 5'd9, 3'd5, 7'h20, 32'h0);
        tick();
        set_req(7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hffff_fffc);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_wr_en", wr_en, 1);
            chk("stall_addr", wr_addr, 0);
            chk("stall_data", wr_data, exp_a[31:0]);
            tick();
        end
        wr_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("second_addr", wr_addr, 4);
        chk("second_data", wr_data, exp_b[31:0]);
        tick();
        chk("drain_wr_en", wr_en, 0);

        // addr_clr coinciding with a completing write at address 8.
        send(7'h37, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'habcd_e000);
        chk("clr_write_addr", wr_addr, 8);
        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        chk("clr_after_addr", wr_addr, BASE_ADDR);

        // Saturate the error counter.
        for (int i = 0; i < (1 << ERRCNT_W) + 2; i++)
            send(7'h7f, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        tick();
        chk("errcnt_sat", err_count, {ERRCNT_W{1'b1}});

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            logic [31:0] im;
            im = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 8191)) - 4096);
            opcode   = $urandom_range(0, 9) == 9 ? 7'($urandom) : ops[$urandom_range(0, 8)];
            rd       = 5'($urandom);
            rs1      = 5'($urandom);
            rs2      = 5'($urandom);
            funct3   = 3'($urandom);
            funct7   = 7'($urandom);
            imm      = im;
            in_valid = $urandom_range(0, 3) != 0;
            wr_ready = $urandom_range(0, 3) != 0;
            addr_clr = $urandom_range(0, 19) == 0;
            tick();
        end
        in_valid = 1'b0; addr_clr = 1'b0; wr_ready = 1'b1;
        tick();
        tick();

        // Asynchronous reset in the middle of a stall.
        wr_ready = 1'b0;
        send(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd9);
        chk("pre_rst_wr_en", wr_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_wr_en", wr_en, 0);
        chk("async_wr_addr", wr_addr, BASE_ADDR);
        chk("async_err_count", err_count, 0);
        chk("async_wr_data", wr_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_ready = 1'b1;
        tick();
        send(7'h17, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0001_0000);
        chk("post_rst_data", wr_data, 32'h0001_0297);
        chk("post_rst_addr", wr_addr, BASE_ADDR);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
